// File: rtl/sram_port_master.sv
// sram_port_master: drives a single-port SRAM from a valid/ready request port.
// Optional SRAM_PORT_MASTER_RANGE_CHECK_EN flags word addresses >= MEM_DEPTH_WORDS.
module sram_port_master #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MEM_ADDR_WIDTH  = 30,
    parameter int RESP_DEPTH      = 3,
    parameter int MEM_DEPTH_WORDS = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_WIDTH-1:0]     resp_rdata,
    output logic                      resp_err,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic                      mem_we,
    output logic                      mem_ce,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int OFFS = $clog2(DATA_WIDTH / 8);
    localparam int PW   = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW   = $clog2(RESP_DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(RESP_DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(RESP_DEPTH);

    logic                  accept;
    logic                  hit;
    logic                  pend_vld;
    logic                  pend_we;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [DATA_WIDTH-1:0] push_data;
    logic [CW-1:0]         fifo_cnt;
    logic [CW-1:0]         occupancy;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_data [RESP_DEPTH];

    assign word_addr = req_addr >> OFFS;

    // Credit covers queued plus in-flight entries, so a push always has room.
    assign occupancy = fifo_cnt + CW'(pend_vld);
    assign req_ready = i_rst_n && (occupancy < CNT_MAX);
    assign accept    = req_valid && req_ready;

`ifdef SRAM_PORT_MASTER_RANGE_CHECK_EN
    logic pend_err;
    logic push_err;
    logic fifo_err [RESP_DEPTH];

    // Out-of-range requests take a queue slot but never touch the SRAM.
    assign hit       = accept && (word_addr < ADDR_WIDTH'(MEM_DEPTH_WORDS));
    assign push_err  = pend_err;
    assign push_data = (pend_we || pend_err) ? '0 : mem_rdata;
    assign resp_err  = resp_valid && fifo_err[rd_ptr];

    // Error flag travels alongside the in-flight stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) pend_err <= 1'b0;
        else          pend_err <= accept && !hit;
    end

    // Error flag storage shares the data queue's pointers.
    always_ff @(posedge i_clk) begin
        if (push) fifo_err[wr_ptr] <= push_err;
    end
`else
    logic unused_bits;

    assign hit         = accept;
    assign push_data   = pend_we ? '0 : mem_rdata;
    assign resp_err    = 1'b0;
    assign unused_bits = ^{word_addr, 32'(MEM_DEPTH_WORDS)};
`endif

    assign mem_ce    = hit;
    assign mem_we    = hit && req_we;
    assign mem_addr  = accept ? MEM_ADDR_WIDTH'(word_addr) : '0;
    assign mem_wdata = accept ? req_wdata : '0;

    assign push       = pend_vld;
    assign resp_valid = (fifo_cnt != '0);
    assign pop        = resp_valid && resp_ready;
    assign resp_rdata = resp_valid ? fifo_data[rd_ptr] : '0;

    // In-flight stage lines up with the SRAM's one-cycle read latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_vld <= 1'b0;
            pend_we  <= 1'b0;
        end else begin
            pend_vld <= accept;
            pend_we  <= accept && req_we;
        end
    end

    // Response payload storage; validity is tracked by the count.
    always_ff @(posedge i_clk) begin
        if (push) fifo_data[wr_ptr] <= push_data;
    end

    // Queue pointers wrap at RESP_DEPTH, so any depth works.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
        end
    end

    // Occupancy count; simultaneous push and pop leave it unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fifo_cnt <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: doc/sram_port_master.md
Name: sram_port_master

Overview:
- Initiator-side controller for the single-port generic SRAM bank used for SCR1 instruction/data storage.
- Accepts core-side byte-addressed requests over a valid/ready handshake.
- Drives the SRAM ce/we/addr/wdata port and captures the 1-cycle-latency read data.
- Returns in-order responses through a backpressurable response FIFO, so the core never has to track SRAM timing.

Parameters:
- ADDR_WIDTH, 32, core-side byte-address width.
- DATA_WIDTH, 32, data width; must be 8·2^k, with k ≥ 0.
- MEM_ADDR_WIDTH, 30, SRAM word-address width (ADDR_WIDTH − log2(DATA_WIDTH/8)).
- RESP_DEPTH, 3, response FIFO depth; must be ≥ 2. A value ≥ 3 is required for 1 request/cycle throughput.
- MEM_DEPTH_WORDS, 1024, implemented word count; used only by the optional feature.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address; the low log2(DATA_WIDTH/8) bits are ignored.
- req_wdata  in  DATA_WIDTH  write data.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumed when resp_valid && resp_ready.
- resp_rdata  out  DATA_WIDTH  read data; 0 for write responses.
- resp_err  out  1  error flag; tied 0 unless the optional feature is enabled.
- mem_addr  out  MEM_ADDR_WIDTH  SRAM word address.
- mem_wdata  out  DATA_WIDTH  SRAM write data.
- mem_we  out  1  SRAM write enable.
- mem_ce  out  1  SRAM chip enable.
- mem_rdata  in  DATA_WIDTH  SRAM read data; valid the cycle after a read with ce=1 and we=0.

Behaviour:
- Reset (async assert, sync deassert by the user):
  - req_ready=0 while i_rst_n=0; resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - FIFO empty; in-flight flag cleared.
- Accept = req_valid && req_ready.
- SRAM drive is combinational from the accepted request, in the same cycle:
  - mem_ce = accept.
  - mem_we = accept && req_we.
  - mem_addr = req_addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)].
  - mem_wdata = req_wdata.
  - When not accepting, mem_we=0 and mem_ce=0; addr/wdata are don't-care but must not be X after reset.
- In-flight stage: on accept, pend_vld←1 and pend_we←req_we; otherwise pend_vld←0.
- The cycle after accept, pend is pushed into the response FIFO:
  - rdata = pend_we ? 0 : mem_rdata.
  - err = 0.
  - The SRAM holds rdata on writes; the block must not forward it.
- Credit rule: req_ready = (fifo_count + pend_vld) < RESP_DEPTH.
  - No combinational path from resp_ready to req_ready.
  - No path from req_valid to req_ready.
  - A FIFO push is therefore always guaranteed space; overflow is impossible by construction.
- FIFO behaviour:
  - Show-ahead: resp_* are driven from the head entry.
  - resp_valid = (fifo_count ≠ 0).
  - Simultaneous push and pop: count unchanged, data ordering preserved.
  - Pop when empty cannot occur.
  - Pointers wrap modulo RESP_DEPTH; supports non-power-of-2 depth.
- Latency: request accepted at cycle N → resp_valid at cycle N+2 at the earliest (FIFO registered).
- Ordering: responses are strictly in request order; reads and writes are interleaved in a single queue.
- Read-after-write to the same address, back-to-back: the SRAM returns the new data, since the write occurs at edge N and the read is issued at N+1. The block performs no hazard handling.
- Reset mid-operation: in-flight and queued responses are discarded; no SRAM access is issued during reset.

Optional Feature:
- Macro: SRAM_PORT_MASTER_RANGE_CHECK_EN.
- Defined:
  - A request with word address ≥ MEM_DEPTH_WORDS is accepted under the normal credit rule.
  - It asserts neither mem_ce nor mem_we.
  - It produces a response 2 cycles later with resp_err=1 and resp_rdata=0, in order.
- Undefined:
  - No range compare logic.
  - resp_err is tied to 0.
  - All addresses access the SRAM, which wraps by the SRAM's own address decoding.

Test Plan:
- Reset, then idle:
  - During reset, req_ready=0, mem_ce=0, resp_valid=0.
  - After reset, req_ready=1 and no mem_ce pulses occur.
- Write 0xDEADBEEF at byte addr 0x10, then read 0x10 with resp_ready=1:
  - mem_addr=0x4 on both accesses.
  - The write response has rdata=0.
  - The read response has rdata 0xDEADBEEF, 2 cycles after its accept.
- Stream 8 reads on consecutive cycles to 0x0,0x4,…,0x1C with resp_ready=1 and RESP_DEPTH=3:
  - req_ready is held at 1 throughout.
  - 8 in-order responses arrive on 8 consecutive cycles.
- Hold resp_ready=0 and issue 5 reads:
  - Exactly 3 are accepted, then req_ready=0.
  - Releasing resp_ready drains 3 responses in order, then the remaining reads are accepted.
- Assert i_rst_n=0 with 2 responses queued and 1 in flight:
  - resp_valid=0 immediately.
  - After release, no stale responses appear.
- With SRAM_PORT_MASTER_RANGE_CHECK_EN and MEM_DEPTH_WORDS=1024, read byte addr 0x1000:
  - mem_ce stays 0.
  - The response has resp_err=1 and rdata=0.
  - A following read to 0x0 returns normal data with err=0.
